multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multicycle RV32I core. Decodes the opcode fields of the latched instruction register. Sequences fetch, decode, execute, memory and writeback over 3–5 cycles. Drives every datapath mux select and write enable, including `ImmSrc` for the immediate extender.

## Interface
Parameters: none. All encodings come from the shared package.

- `clk` input 1: core clock; all state changes on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `Op` input 7: `Instr[6:0]` from the instruction register.
- `Funct3` input 3: `Instr[14:12]`.
- `Funct7b5` input 1: `Instr[30]`.
- `Zero` input 1: ALU zero flag for the current cycle.
- `PCWrite` output 1: PC register enable.
- `AdrSrc` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemWrite` output 1: data memory write enable.
- `IRWrite` output 1: instruction register and OldPC enable.
- `RegWrite` output 1: register file write enable.
- `ResultSrc` output 2: result select; 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- `ALUSrcA` output 2: ALU A select; 00 = PC, 01 = OldPC, 10 = RD1.
- `ALUSrcB` output 2: ALU B select; 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `ImmSrc` output 3: immediate format; 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `ALUControl` output 3: ALU operation; 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `IllegalInstr` output 1: unsupported opcode trapped.

## Operation
**State register**
- Registered Moore FSM.
- Outputs are a combinational function of state, except `ImmSrc`, `ALUControl` and the `PCWrite` branch term.
- Unlisted outputs are 0 in every state.

**States and transitions**
- FETCH: `IRWrite`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, ALUOp=add, `ResultSrc`=10, PCUpdate=1 → DECODE.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=01, ALUOp=add (precomputes branch target). Next state by `Op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - 0110111 → LUI
  - other → FETCH (see Configuration)
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, add → MEMREAD if `Op`=0000011, else MEMWRITE.
- MEMREAD: `AdrSrc`=1, `ResultSrc`=00 → MEMWB.
- MEMWB: `ResultSrc`=01, `RegWrite`=1 → FETCH.
- MEMWRITE: `AdrSrc`=1, `MemWrite`=1 → FETCH.
- EXECR: `ALUSrcA`=10, `ALUSrcB`=00, ALUOp=funct → ALUWB.
- EXECI: `ALUSrcA`=10, `ALUSrcB`=01, ALUOp=funct → ALUWB.
- ALUWB: `ResultSrc`=00, `RegWrite`=1 → FETCH.
- JAL: `ALUSrcA`=01, `ALUSrcB`=10, add, `ResultSrc`=00, PCUpdate=1 → ALUWB.
- BEQ: `ALUSrcA`=10, `ALUSrcB`=00, ALUOp=sub, `ResultSrc`=00, Branch=1 → FETCH.
- LUI: `ResultSrc`=11, `RegWrite`=1 → FETCH.

**Derived outputs**
- `PCWrite` = PCUpdate | (Branch & `Zero`).
- `ImmSrc` is decoded from `Op` in every state:
  - 0100011 → 001
  - 1100011 → 010
  - 1101111 → 011
  - 0110111 → 100
  - else → 000

**ALU decode**
- ALUOp add → 000; sub → 001.
- ALUOp funct, by `Funct3`:
  - 000 → 001 if (`Funct7b5` & `Op[5]`), else 000
  - 010 → 101
  - 110 → 011
  - 111 → 010
  - other → 000

## Timing
- **Reset:** `reset_n`=0 at an edge sets state to FETCH. While `reset_n`=0, `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` and `IllegalInstr` are forced 0. Mux selects show FETCH values. The first cycle with `reset_n`=1 is a real FETCH.
- **Reset mid-instruction:** aborts the instruction. No write enable is asserted in the reset cycle.
- **Cycles per instruction:** lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, lui 3, unsupported opcode 2.
- **Branch:** `Zero` is sampled combinationally in BEQ only. A taken branch loads the DECODE-computed target on the BEQ edge.
- **`Op` stability:** `Op` is only meaningful from DECODE onward. `ImmSrc` may glitch during FETCH; harmless because `ALUSrcB` ≠ 01 in FETCH.

## Configuration
Macro `RV_ILLEGAL_TRAP_EN`.

- **Defined:**
  - An unsupported `Op` in DECODE → TRAP.
  - TRAP holds `IllegalInstr`=1 with all write enables 0.
  - TRAP is left only by reset.
- **Undefined:**
  - No TRAP state.
  - An unsupported `Op` returns to FETCH as a 2-cycle NOP.
  - `IllegalInstr` is tied 0.

## Structure
- **Package `riscv_ctrl_pkg`:**
  - opcode constants
  - state enumeration
  - `ImmSrc`, ALUOp, `ALUControl`, `ResultSrc`, `ALUSrcA`/`ALUSrcB` encodings
- **Sub-module `alu_decoder`:** maps (ALUOp, `Funct3`, `Funct7b5`, `Op[5]`) → `ALUControl`. Purely combinational.
- **FSM and `ImmSrc` decode:** stay in `multicycle_controller`.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles with arbitrary `Op` → all enables 0 throughout. First post-reset cycle shows `IRWrite`=1, `PCWrite`=1.
- **lw then sw:** `Op`=0000011 then 0100011 →
  - lw: states F,D,MA,MR,MWB (5 cycles); `RegWrite` only in MWB with `ResultSrc`=01.
  - sw: 4 cycles; `MemWrite`=1 only in MEMWRITE; `ImmSrc`=001.
- **beq with `Zero`=1 and `Zero`=0:**
  - both: 3 cycles, `ALUControl`=001, `ImmSrc`=010.
  - `Zero`=1: `PCWrite`=1 in BEQ.
  - `Zero`=0: `PCWrite`=0 in BEQ.
- **R-type sub:** `Op`=0110011, `Funct3`=000, `Funct7b5`=1 → `ALUControl`=001 in EXECR.
- **I-type addi:** `Funct7b5`=1 → `ALUControl`=000 (`Op[5]`=0).
- **jal:** `Op`=1101111 → `ImmSrc`=011; `PCWrite`=1 in JAL; `RegWrite`=1 in ALUWB.
- **lui:** `Op`=0110111 → `ImmSrc`=100; `ResultSrc`=11; 3 cycles.
- **Illegal opcode:** `Op`=1111111 →
  - with macro: TRAP, `IllegalInstr`=1 held until reset.
  - without macro: back to FETCH after 2 cycles, `IllegalInstr`=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states and mux selects.
// The TRAP state exists only when RV_ILLEGAL_TRAP_EN is defined.
package riscv_ctrl_pkg;

    localparam int unsigned OP_W    = 7;
    localparam int unsigned IMM_W   = 3;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned SEL_W   = 2;

    localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_LUI
`ifdef RV_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} aluop_t;

    typedef enum logic [IMM_W-1:0] {
        IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [ALUC_W-1:0] {
        ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [SEL_W-1:0] {
        RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10, RES_IMMEXT = 2'b11
    } result_src_t;

    typedef enum logic [SEL_W-1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10} srca_t;
    typedef enum logic [SEL_W-1:0] {SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} srcb_t;

    // Immediate format straight from the opcode, independent of FSM state.
    function automatic imm_src_t imm_src_decode(input logic [OP_W-1:0] op);
        case (op)
            OP_STORE: return IMM_S;
            OP_BEQ:   return IMM_B;
            OP_JAL:   return IMM_J;
            OP_LUI:   return IMM_U;
            default:  return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle; master is the controller, slave the datapath.
interface multicycle_controller_if;
    logic [6:0] Op;
    logic [2:0] Funct3;
    logic       Funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       IllegalInstr;

    modport master (
        input  Op, Funct3, Funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr
    );

    modport slave (
        output Op, Funct3, Funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from ALUOp and the funct fields; purely combinational.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output alu_ctrl_t  alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (funct7b5 & op5) ? ALU_SUB : ALU_ADD; // addi never subtracts
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: Moore state machine driving all datapath selects/enables.
// Define RV_ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky TRAP state instead of a 2-cycle NOP.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input logic                      clk,
    input logic                      reset_n,
    multicycle_controller_if.master  bus
);

    state_t      state, state_eff, state_next;
    logic        pcupdate, branch, adrsrc, memwrite, irwrite, regwrite;
    result_src_t resultsrc;
    srca_t       alusrca;
    srcb_t       alusrcb;
    aluop_t      aluop;
    alu_ctrl_t   alucontrol;
`ifdef RV_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_next;
    end

    // While in reset the selects present FETCH values regardless of the stored state.
    assign state_eff = reset_n ? state : S_FETCH;

    always_comb begin
        state_next = state_eff;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        adrsrc     = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        resultsrc  = RES_ALUOUT;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_RD2;
        aluop      = ALUOP_ADD;
`ifdef RV_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif
        case (state_eff)
            S_FETCH: begin
                irwrite    = 1'b1;
                alusrcb    = SRCB_FOUR;
                resultsrc  = RES_ALURESULT;
                pcupdate   = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                case (bus.Op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BEQ:            state_next = S_BEQ;
                    OP_LUI:            state_next = S_LUI;
`ifdef RV_ILLEGAL_TRAP_EN
                    default:           state_next = S_TRAP;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alusrca    = SRCA_RD1;
                alusrcb    = SRCB_IMM;
                state_next = (bus.Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc  = RES_DATA;
                regwrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECR: begin
                alusrca    = SRCA_RD1;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alusrca    = SRCA_RD1;
                alusrcb    = SRCB_IMM;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                pcupdate   = 1'b1;
                state_next = S_ALUWB;
            end
            S_BEQ: begin
                alusrca    = SRCA_RD1;
                aluop      = ALUOP_SUB;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            S_LUI: begin
                resultsrc  = RES_IMMEXT;
                regwrite   = 1'b1;
                state_next = S_FETCH;
            end
`ifdef RV_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal    = 1'b1;
                state_next = S_TRAP;
            end
`endif
            default: state_next = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (bus.Funct3),
        .funct7b5   (bus.Funct7b5),
        .op5        (bus.Op[5]),
        .alucontrol (alucontrol)
    );

    // Write enables are gated by reset so an aborted instruction commits nothing.
    assign bus.PCWrite    = reset_n & (pcupdate | (branch & bus.Zero));
    assign bus.IRWrite    = reset_n & irwrite;
    assign bus.RegWrite   = reset_n & regwrite;
    assign bus.MemWrite   = reset_n & memwrite;
    assign bus.AdrSrc     = adrsrc;
    assign bus.ResultSrc  = resultsrc;
    assign bus.ALUSrcA    = alusrca;
    assign bus.ALUSrcB    = alusrcb;
    assign bus.ALUControl = alucontrol;
    assign bus.ImmSrc     = imm_src_decode(bus.Op);
`ifdef RV_ILLEGAL_TRAP_EN
    assign bus.IllegalInstr = reset_n & illegal;
`else
    assign bus.IllegalInstr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors queued, then popped at negedge.
module tb_multicycle_controller;

    localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4, ST_MW = 5, ST_ER = 6,
                   ST_EI = 7, ST_AWB = 8, ST_J = 9, ST_B = 10, ST_L = 11, ST_T = 12, ST_RST = 13;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    int         errors = 0;
    int         checks = 0;
    logic [17:0] expq[$];
    string       tagq[$];
    logic [17:0] obs;

    always #5 clk = ~clk;

    multicycle_controller_if bus();

    assign bus.Op       = op;
    assign bus.Funct3   = f3;
    assign bus.Funct7b5 = f7;
    assign bus.Zero     = zero;

    multicycle_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.IllegalInstr};

    // Expected outputs for one state, written out from the state table.
    function automatic logic [17:0] model(input int st, input logic [6:0] o, input logic [2:0] fn3,
                                          input logic fn7, input logic z);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm, alu;
        int aop;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 0;
        case (o)
            7'b0100011: imm = 3'b001;
            7'b1100011: imm = 3'b010;
            7'b1101111: imm = 3'b011;
            7'b0110111: imm = 3'b100;
            default:    imm = 3'b000;
        endcase
        case (st)
            ST_F:   begin irw = 1; sb = 2'b10; rs = 2'b10; pcw = 1; end
            ST_D:   begin sa = 2'b01; sb = 2'b01; end
            ST_MA:  begin sa = 2'b10; sb = 2'b01; end
            ST_MR:  adr = 1;
            ST_MWB: begin rs = 2'b01; rw = 1; end
            ST_MW:  begin adr = 1; mw = 1; end
            ST_ER:  begin sa = 2'b10; aop = 2; end
            ST_EI:  begin sa = 2'b10; sb = 2'b01; aop = 2; end
            ST_AWB: rw = 1;
            ST_J:   begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            ST_B:   begin sa = 2'b10; aop = 1; pcw = z; end
            ST_L:   begin rs = 2'b11; rw = 1; end
            ST_T:   ill = 1;
            default: begin sb = 2'b10; rs = 2'b10; end
        endcase
        if (aop == 1) alu = 3'b001;
        else if (aop == 2) begin
            case (fn3)
                3'b000:  alu = (fn7 & o[5]) ? 3'b001 : 3'b000;
                3'b010:  alu = 3'b101;
                3'b110:  alu = 3'b011;
                3'b111:  alu = 3'b010;
                default: alu = 3'b000;
            endcase
        end else alu = 3'b000;
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    task automatic push(input int st, input string tag);
        expq.push_back(model(st, op, f3, f7, zero));
        tagq.push_back(tag);
    endtask

    task automatic drain();
        logic [17:0] e;
        string t;
        while (expq.size() > 0) begin
            @(negedge clk);
            e = expq.pop_front();
            t = tagq.pop_front();
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", t, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [6:0] o, input logic [2:0] fn3, input logic fn7, input logic z,
                       input string name);
        op = o; f3 = fn3; f7 = fn7; zero = z;
        push(ST_F, {name, "/fetch"});
        push(ST_D, {name, "/decode"});
        case (o)
            7'b0000011: begin push(ST_MA, {name, "/memadr"}); push(ST_MR, {name, "/memread"});
                              push(ST_MWB, {name, "/memwb"}); end
            7'b0100011: begin push(ST_MA, {name, "/memadr"}); push(ST_MW, {name, "/memwrite"}); end
            7'b0110011: begin push(ST_ER, {name, "/execr"}); push(ST_AWB, {name, "/aluwb"}); end
            7'b0010011: begin push(ST_EI, {name, "/execi"}); push(ST_AWB, {name, "/aluwb"}); end
            7'b1101111: begin push(ST_J, {name, "/jal"}); push(ST_AWB, {name, "/aluwb"}); end
            7'b1100011: push(ST_B, {name, "/beq"});
            7'b0110111: push(ST_L, {name, "/lui"});
            default: begin
`ifdef RV_ILLEGAL_TRAP_EN
                for (int i = 0; i < 3; i++) push(ST_T, {name, "/trap"});
`endif
            end
        endcase
        drain();
    endtask

    task automatic reset_cycles(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            op = 7'($urandom); f3 = 3'($urandom); f7 = 1'($urandom); zero = 1'($urandom);
            push(ST_RST, "reset");
            drain();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        op = 7'b0; f3 = 3'b0; f7 = 1'b0; zero = 1'b0;
        reset_cycles(3);

        run(7'b0000011, 3'b010, 1'b0, 1'b1, "lw");
        run(7'b0100011, 3'b010, 1'b1, 1'b1, "sw");
        run(7'b1100011, 3'b000, 1'b0, 1'b1, "beq_taken");
        run(7'b1100011, 3'b000, 1'b0, 1'b0, "beq_not_taken");
        run(7'b0110011, 3'b000, 1'b1, 1'b0, "r_sub");
        run(7'b0110011, 3'b000, 1'b0, 1'b0, "r_add");
        run(7'b0110011, 3'b010, 1'b0, 1'b1, "r_slt");
        run(7'b0110011, 3'b110, 1'b0, 1'b0, "r_or");
        run(7'b0110011, 3'b111, 1'b0, 1'b0, "r_and");
        run(7'b0110011, 3'b100, 1'b0, 1'b0, "r_xor_default");
        run(7'b0010011, 3'b000, 1'b1, 1'b0, "addi_f7");
        run(7'b0010011, 3'b010, 1'b0, 1'b0, "slti");
        run(7'b1101111, 3'b000, 1'b0, 1'b0, "jal");
        run(7'b0110111, 3'b000, 1'b0, 1'b1, "lui");
        run(7'b1111111, 3'b000, 1'b0, 1'b0, "illegal");
`ifdef RV_ILLEGAL_TRAP_EN
        reset_cycles(1);
`endif
        run(7'b0110111, 3'b001, 1'b1, 1'b0, "lui_after_illegal");

        // Abort a load in MEMADR; nothing must be written and FETCH restarts cleanly.
        op = 7'b0000011; f3 = 3'b010; f7 = 1'b0; zero = 1'b0;
        push(ST_F, "abort/fetch");
        push(ST_D, "abort/decode");
        push(ST_MA, "abort/memadr");
        drain();
        reset_cycles(1);
        run(7'b0100011, 3'b010, 1'b0, 1'b0, "sw_after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
